dla_glb_sequencer: RTL



---
 rtl/dla_glb_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/dla_glb_sequencer.sv
// Global register/status block: snapshots config into a command queue on each go,
// dispatches one op at a time to the subunits, and raises W1C completion interrupts.
module dla_glb_sequencer #(
  parameter int                NUM_OP   = 6,
  parameter int                QDEPTH   = 4,
  parameter logic [NUM_OP-1:0] LPE_MASK = 6'b101100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_OP-1:0] go,
  input  logic [NUM_OP-1:0] complete,
  input  logic              complete_lpe,
  output logic [NUM_OP-1:0] start,
  input  logic [31:0]       regif_wdata,
  input  logic              glb_intr_wen,
  input  logic              glb_intr_en_wen,
  input  logic              glb_enable_row_wen,
  input  logic              glb_enable_col_wen,
  input  logic              comp_precision_wen,
  output logic [31:0]       glb_status_rdata,
  output logic [31:0]       glb_intr_rdata,
  output logic [31:0]       glb_intr_en_rdata,
  output logic [31:0]       glb_enable_row_rdata,
  output logic [31:0]       glb_enable_col_rdata,
  output logic [31:0]       comp_precision_rdata,
  output logic [31:0]       glb_count_rdata,
  output logic [15:0]       stgr_enable_row,
  output logic [15:0]       stgr_enable_col,
  output logic [3:0]        stgr_precision_ape_shift,
  output logic [3:0]        stgr_precision_kpe_shift,
  output logic              stgr_precision_ifmap,
  output logic [1:0]        stgr_precision_weight,
  output logic              busy,
  output logic              interrupt
);
  localparam int QAW = $clog2(QDEPTH);
  localparam logic [QAW:0] QFULL = (QAW+1)'(QDEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  // Op is kept one-hot end to end so it can drive start/pending/status directly.
  typedef struct packed {
    logic [NUM_OP-1:0] op;
    logic [15:0]       row;
    logic [15:0]       col;
    logic [3:0]        ape;
    logic [3:0]        kpe;
    logic              ifmap;
    logic [1:0]        weight;
  } cmd_t;

  cmd_t              q_mem [QDEPTH];
  cmd_t              push_cmd, head;
  logic [QAW-1:0]    wptr, rptr;
  logic [QAW:0]      level;
  logic [1:0]        state;
  logic [NUM_OP-1:0] cur_oh, pending, intr_en, intr_clr;
  logic [15:0]       en_row, en_col, done_cnt;
  logic [3:0]        ape, kpe;
  logic              ifmap;
  logic [1:0]        weight;
  logic              err_ovf, err_multi;
  logic              do_push, do_pop, multi, run_done, fin;
  logic              unused_wdata;

  assign head     = q_mem[rptr];
  assign do_pop   = (state == S_IDLE) && (level != '0);
  // Fullness is judged on the pre-edge level, so a same-edge pop never frees a slot.
  assign do_push  = (|go) && (level != QFULL);
  assign multi    = |(go & (go - NUM_OP'(1)));
  assign run_done = (state == S_RUN) && (|(complete & cur_oh));
  assign fin      = (run_done && !(|(LPE_MASK & cur_oh))) ||
                    ((state == S_WAIT) && complete_lpe);
  assign intr_clr = glb_intr_wen ? regif_wdata[NUM_OP-1:0] : '0;
  assign unused_wdata = ^{regif_wdata[31:30], regif_wdata[23:20]};

  always_comb begin
    push_cmd        = '0;
    push_cmd.op     = go & (~go + NUM_OP'(1));
    push_cmd.row    = en_row;
    push_cmd.col    = en_col;
    push_cmd.ape    = ape;
    push_cmd.kpe    = kpe;
    push_cmd.ifmap  = ifmap;
    push_cmd.weight = weight;
  end

  always_ff @(posedge clk) begin
    if (do_push) q_mem[wptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                    <= S_IDLE;
      level                    <= '0;
      wptr                     <= '0;
      rptr                     <= '0;
      cur_oh                   <= '0;
      start                    <= '0;
      stgr_enable_row          <= '0;
      stgr_enable_col          <= '0;
      stgr_precision_ape_shift <= '0;
      stgr_precision_kpe_shift <= '0;
      stgr_precision_ifmap     <= 1'b0;
      stgr_precision_weight    <= '0;
      pending                  <= '0;
      err_ovf                  <= 1'b0;
      err_multi                <= 1'b0;
      done_cnt                 <= '0;
      en_row                   <= 16'hffff;
      en_col                   <= 16'hffff;
      ape                      <= '0;
      kpe                      <= '0;
      ifmap                    <= 1'b0;
      weight                   <= '0;
      intr_en                  <= '1;
    end else begin
      level <= level + (QAW+1)'(do_push) - (QAW+1)'(do_pop);
      if (do_push) wptr <= wptr + QAW'(1);
      if (do_pop)  rptr <= rptr + QAW'(1);
      start <= do_pop ? head.op : '0;
      if (do_pop) begin
        cur_oh                   <= head.op;
        stgr_enable_row          <= head.row;
        stgr_enable_col          <= head.col;
        stgr_precision_ape_shift <= head.ape;
        stgr_precision_kpe_shift <= head.kpe;
        stgr_precision_ifmap     <= head.ifmap;
        stgr_precision_weight    <= head.weight;
      end
      case (state)
        S_IDLE:  if (do_pop) state <= S_START;
        S_START: state <= S_RUN;
        S_RUN:   if (run_done) state <= fin ? S_IDLE : S_WAIT;
        default: if (complete_lpe) state <= S_IDLE;
      endcase
      // Clear first, then OR in this edge's sets so a same-edge set wins.
      pending   <= (pending & ~intr_clr) | (fin ? cur_oh : '0);
      err_ovf   <= (err_ovf & ~(glb_intr_wen & regif_wdata[29])) | ((|go) & ~do_push);
      err_multi <= (err_multi & ~(glb_intr_wen & regif_wdata[28])) | multi;
      if (fin) done_cnt <= done_cnt + 16'd1;
      if (glb_intr_en_wen)    intr_en <= regif_wdata[NUM_OP-1:0];
      if (glb_enable_row_wen) en_row  <= regif_wdata[15:0];
      if (glb_enable_col_wen) en_col  <= regif_wdata[15:0];
      if (comp_precision_wen) begin
        ape    <= regif_wdata[27:24];
        kpe    <= regif_wdata[19:16];
        ifmap  <= regif_wdata[8];
        weight <= regif_wdata[1:0];
      end
    end
  end

  assign busy      = (state != S_IDLE) || (level != '0);
  assign interrupt = |(pending & intr_en);

  always_comb begin
    glb_status_rdata              = '0;
    glb_status_rdata[31]          = busy;
    glb_status_rdata[30]          = (state == S_WAIT);
    glb_status_rdata[16 +: QAW+1] = level;
    if (state != S_IDLE) glb_status_rdata[NUM_OP-1:0] = cur_oh;

    glb_intr_rdata                = '0;
    glb_intr_rdata[29]            = err_ovf;
    glb_intr_rdata[28]            = err_multi;
    glb_intr_rdata[NUM_OP-1:0]    = pending;

    glb_intr_en_rdata             = '0;
    glb_intr_en_rdata[NUM_OP-1:0] = intr_en;

    comp_precision_rdata          = '0;
    comp_precision_rdata[27:24]   = ape;
    comp_precision_rdata[19:16]   = kpe;
    comp_precision_rdata[8]       = ifmap;
    comp_precision_rdata[1:0]     = weight;
  end

  assign glb_enable_row_rdata = {16'b0, en_row};
  assign glb_enable_col_rdata = {16'b0, en_col};
  assign glb_count_rdata      = {16'b0, done_cnt};
endmodule
